// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port data RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

    localparam int N_REQ_DEF  = 2;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sel    = '0;
        // Search order starts one past the previous winner so nobody starves.
        for (int k = 1; k <= N_REQ; k++) begin
            sel = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                winner     = sel;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU LSU and the debug loader.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              rvalid,
    output logic [N_REQ-1:0]              err,
    output logic [DATA_W-1:0]             rdata,
    output logic                          ram_write_enable,
    output logic                          ram_read,
    output logic [ADDR_W-1:0]             ram_address,
    output logic [DATA_W-1:0]             ram_write_data,
    input  logic [DATA_W-1:0]             ram_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  last_grant, winner, op_idx;
    logic [N_REQ-1:0]  grant;
    logic              op_we, op_in_range, win_in_range, latch;
    logic [ADDR_W-1:0] op_addr, addr_nxt;
    logic [DATA_W-1:0] op_wdata, wdata_nxt;
    logic              we_q, we_nxt, rd_nxt;
    logic [N_REQ-1:0]  ack_q, rvalid_q, err_q, ack_nxt, rvalid_nxt, err_nxt;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    // Full-width compare: high address bits must never alias onto a real entry.
    assign win_in_range = req_addr[winner] < ADDR_W'(DEPTH);

    always_comb begin
        state_nxt  = state;
        latch      = 1'b0;
        we_nxt     = 1'b0;
        rd_nxt     = 1'b0;
        addr_nxt   = '0;
        wdata_nxt  = '0;
        ack_nxt    = '0;
        rvalid_nxt = '0;
        err_nxt    = '0;
        case (state)
            IDLE: if (|grant) begin
                latch     = 1'b1;
                state_nxt = ACCESS;
                if (win_in_range) begin
                    addr_nxt = req_addr[winner];
                    if (req_we[winner]) begin
                        we_nxt    = 1'b1;
                        wdata_nxt = req_wdata[winner];
                    end else begin
                        rd_nxt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_nxt          = RESP;
                ack_nxt[op_idx]    = 1'b1;
                rvalid_nxt[op_idx] = op_in_range && !op_we;
                err_nxt[op_idx]    = !op_in_range;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(N_REQ - 1);
            op_idx         <= '0;
            op_we          <= 1'b0;
            op_addr        <= '0;
            op_wdata       <= '0;
            op_in_range    <= 1'b0;
            we_q           <= 1'b0;
            ram_read       <= 1'b0;
            ram_address    <= '0;
            ram_write_data <= '0;
            ack_q          <= '0;
            rvalid_q       <= '0;
            err_q          <= '0;
            rdata          <= '0;
        end else begin
            state          <= state_nxt;
            we_q           <= we_nxt;
            ram_read       <= rd_nxt;
            ram_address    <= addr_nxt;
            ram_write_data <= wdata_nxt;
            ack_q          <= ack_nxt;
            rvalid_q       <= rvalid_nxt;
            err_q          <= err_nxt;
            if (latch) begin
                op_idx      <= winner;
                op_we       <= req_we[winner];
                op_addr     <= req_addr[winner];
                op_wdata    <= req_wdata[winner];
                op_in_range <= win_in_range;
            end
            if (ram_read)
                rdata <= ram_data_out;
            if (state == RESP)
                last_grant <= op_idx;
        end
    end

    // A reset landing on ACCESS or RESP must not write the RAM or complete the op.
    assign ram_write_enable = we_q && !reset;
    assign ack              = ack_q    & {N_REQ{!reset}};
    assign rvalid           = rvalid_q & {N_REQ{!reset}};
    assign err              = err_q    & {N_REQ{!reset}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed and random traffic.
module tb_ram_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = '0;
    logic [1:0]       req_we = '0;
    logic [1:0][15:0] req_addr = '0;
    logic [1:0][15:0] req_wdata = '0;
    logic [1:0]       ack, rvalid, err;
    logic [15:0]      rdata, ram_address, ram_write_data, ram_data_out;
    logic             ram_write_enable, ram_read;

    logic [15:0] mem [8];
    logic [15:0] ref_mem [8];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    logic [15:0] we_last_addr = '0;
    int ack_p [$];
    int ack_c [$];

    // Transaction model state: cycles left in the current op (2 = RAM cycle, 1 = response cycle).
    int          left = 0;
    int          last = 1;
    int          cur_p = 0;
    logic        cur_we = 1'b0;
    logic [15:0] cur_a = '0;
    logic [15:0] cur_wd = '0;
    logic [15:0] exp_rdata = '0;

    ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .ack              (ack),
        .rvalid           (rvalid),
        .err              (err),
        .rdata            (rdata),
        .ram_write_enable (ram_write_enable),
        .ram_read         (ram_read),
        .ram_address      (ram_address),
        .ram_write_data   (ram_write_data),
        .ram_data_out     (ram_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_write_enable) mem[ram_address[2:0]] <= ram_write_data;
    assign ram_data_out = (ram_address < 16'd8) ? mem[ram_address[2:0]] : 16'hDEAD;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0]  e_ack, e_rv, e_err;
        logic        e_we, e_rd, inr;
        logic [15:0] e_addr, e_wd;
        e_ack = '0; e_rv = '0; e_err = '0; e_we = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
        inr = cur_a < 16'd8;
        if (left == 2) begin
            e_we   = inr && cur_we && !reset;
            e_rd   = inr && !cur_we;
            e_addr = inr ? cur_a : 16'h0;
            e_wd   = (inr && cur_we) ? cur_wd : 16'h0;
        end else if (left == 1 && !reset) begin
            e_ack[cur_p] = 1'b1;
            e_rv[cur_p]  = inr && !cur_we;
            e_err[cur_p] = !inr;
        end
        chk("m_ack", ack, e_ack);
        chk("m_rvalid", rvalid, e_rv);
        chk("m_err", err, e_err);
        chk("m_ram_we", ram_write_enable, e_we);
        chk("m_ram_read", ram_read, e_rd);
        chk("m_ram_addr", ram_address, e_addr);
        chk("m_ram_wdata", ram_write_data, e_wd);
        chk("m_rdata", rdata, exp_rdata);
        if (ram_write_enable) begin we_cnt++; we_last_addr = ram_address; end
        if (|ack) begin ack_p.push_back(ack[1] ? 1 : 0); ack_c.push_back(cyc); end
        // Advance to what the coming edge does, from the inputs it will sample.
        if (reset) begin
            left = 0; last = 1; exp_rdata = '0;
        end else if (left == 2) begin
            if (inr) begin
                if (cur_we) ref_mem[cur_a[2:0]] = cur_wd;
                else        exp_rdata = ref_mem[cur_a[2:0]];
            end
            left = 1;
        end else if (left == 1) begin
            last = cur_p; left = 0;
        end else if (req != 2'b00) begin
            cur_p = req[(last + 1) % 2] ? (last + 1) % 2 : last;
            cur_we = req_we[cur_p]; cur_a = req_addr[cur_p]; cur_wd = req_wdata[cur_p];
            left = 2;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one request from port p and wait (bounded) for its ack.
    task automatic txn(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input bit drop, output logic [15:0] rd, output logic rv, output logic er,
                       output int lat);
        req[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = wd;
        rd = '0; rv = 1'b0; er = 1'b0; lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack[p]) begin rv = rvalid[p]; er = err[p]; rd = rdata; lat = n; break; end
        end
        chk("ack_seen", lat > 0, 1);
        tick();
        if (drop) req[p] = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        logic [15:0] rd, a;
        logic rv, er, we;
        int lat;
        for (int k = 0; k < n; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(8, 65535)) : 16'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            txn(p, we, a, 16'($urandom), (k == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)), rd, rv, er, lat);
            chk("rand_err", er, a >= 16'd8);
            chk("rand_rvalid", rv, !we && a < 16'd8);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic rv, er;
        int lat, base;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 16'(16'h1000 + 16'h0101 * i);
            ref_mem[i] = 16'(16'h1000 + 16'h0101 * i);
        end
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ack", {ack, rvalid, err}, 0);
        chk("reset_strobes", {ram_write_enable, ram_read}, 0);
        chk("reset_rdata", rdata, 16'h0000);
        tick();

        // Write then read back one location.
        base = we_cnt;
        txn(0, 1'b1, 16'd3, 16'hBEEF, 1'b1, rd, rv, er, lat);
        chk("t1_wr_lat", lat, 3);
        chk("t1_wr_flags", {rv, er}, 0);
        chk("t1_we_once", we_cnt - base, 1);
        chk("t1_we_addr", we_last_addr, 16'd3);
        txn(0, 1'b0, 16'd3, 16'h0, 1'b1, rd, rv, er, lat);
        chk("t1_rd_rvalid", rv, 1);
        chk("t1_rd_data", rd, 16'hBEEF);

        // Contention: fresh reset so port 0 wins first, then strict alternation 3 cycles apart.
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        ack_p.delete(); ack_c.delete();
        req_we = 2'b00; req_addr[0] = 16'd0; req_addr[1] = 16'd1; req = 2'b11;
        repeat (12) tick();
        req = 2'b00;
        repeat (4) tick();
        chk("t2_ack_count", ack_p.size(), 4);
        for (int i = 0; i < ack_p.size(); i++) begin
            chk("t2_ack_port", ack_p[i], i % 2);
            if (i > 0) chk("t2_ack_gap", ack_c[i] - ack_c[i-1], 3);
        end

        // Out-of-range accesses, including one whose low bits alias entry 3.
        base = we_cnt;
        txn(1, 1'b1, 16'h0008, 16'h1234, 1'b1, rd, rv, er, lat);
        chk("t3_err", {er, rv}, 2'b10);
        txn(1, 1'b1, 16'h0103, 16'h5555, 1'b1, rd, rv, er, lat);
        chk("t3_err_hi", er, 1);
        chk("t3_no_we", we_cnt - base, 0);
        txn(1, 1'b0, 16'd0, 16'h0, 1'b1, rd, rv, er, lat);
        chk("t3_addr0", rd, 16'h1000);
        txn(1, 1'b0, 16'd3, 16'h0, 1'b1, rd, rv, er, lat);
        chk("t3_addr3", rd, 16'hBEEF);

        // Reset lands on the RAM cycle of a write.
        ack_p.delete();
        req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'd5; req_wdata[0] = 16'hAAAA;
        tick();
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("t4_we_gated", ram_write_enable, 0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("t4_no_ack", ack_p.size(), 0);
        txn(0, 1'b0, 16'd5, 16'h0, 1'b1, rd, rv, er, lat);
        chk("t4_addr5", rd, 16'h1505);

        // Back-to-back reads with req held across ack.
        txn(0, 1'b0, 16'd2, 16'h0, 1'b0, rd, rv, er, lat);
        chk("t5_rd2", {rv, rd}, {1'b1, 16'h1202});
        txn(0, 1'b0, 16'd7, 16'h0, 1'b1, rd, rv, er, lat);
        chk("t5_rd7", {rv, rd}, {1'b1, 16'h1707});
        chk("t5_lat", lat, 3);

        // Quiet bus: everything zero, rdata holds.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_quiet", {ack, rvalid, err, ram_write_enable, ram_read, ram_address, ram_write_data}, 0);
            chk("t6_rdata_hold", rdata, 16'h1707);
        end
        tick();

        // Random traffic from both ports at once.
        fork
            rand_port(0, 15);
            rand_port(1, 15);
        join
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8-entry x 16-bit data RAM between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/program loader.
- Arbitrates round-robin and sequences each access through a 3-state FSM.
- Registers read data and returns it with a one-cycle ack/rvalid pulse.
- Rejects out-of-range addresses with an error instead of letting them alias.

Parameters:
- N_REQ, 2: number of requesters. Fixed at 2 for this revision; the RTL is written generically.
- ADDR_W, 16: requester address width.
- DATA_W, 16: data width.
- DEPTH, 8: number of valid RAM locations. Addresses >= DEPTH are errors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level, held until ack.
- req_we  in  N_REQ  1 = write, 0 = read; held with req.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- req_wdata  in  N_REQ*DATA_W  packed write data.
- ack  out  N_REQ  one-cycle completion pulse.
- rvalid  out  N_REQ  one-cycle pulse with ack on a successful read.
- err  out  N_REQ  one-cycle pulse with ack on an out-of-range address.
- rdata  out  DATA_W  read data, valid while rvalid is high.
- ram_write_enable  out  1  to RAM write_enable.
- ram_read  out  1  to RAM ram_read.
- ram_address  out  ADDR_W  to RAM access_address.
- ram_write_data  out  DATA_W  to RAM write_data.
- ram_data_out  in  DATA_W  from RAM data_out (combinational read).

Behaviour:
- Reset values:
  - state=IDLE; last_grant=N_REQ-1, so port 0 wins first.
  - ack, rvalid, err, ram_write_enable, ram_read = 0.
  - ram_address, ram_write_data, rdata = 0.
  - Latched op registers = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick a winner by round-robin: the first set bit searching from last_grant+1, wrapping.
  - Latch winner index, we, addr and wdata; go to ACCESS.
  - If req is all zero, stay in IDLE.
- ACCESS (exactly one cycle):
  - If latched addr < DEPTH:
    - Drive ram_address = addr.
    - Write: ram_write_enable=1 and ram_write_data=wdata.
    - Read: ram_read=1, and capture ram_data_out into rdata at the closing edge.
  - If addr >= DEPTH: drive no RAM strobes and set the error flag.
  - Go to RESP.
- RESP (one cycle):
  - ack[winner]=1.
  - rvalid[winner]=1 only for an in-range read.
  - err[winner]=1 only for an out-of-range access.
  - last_grant <= winner; go to IDLE.
- Latency and throughput:
  - req seen in IDLE at edge N produces ack high during cycle N+2.
  - Throughput is one transaction per 3 cycles.
- Handshake rules:
  - A requester must hold req, we, addr and wdata stable until it sees ack.
  - It drops req in the cycle after ack, or keeps it high to issue a new request, which is re-arbitrated in IDLE.
  - A req that falls before ack is a protocol violation; the latched operation still completes and acks.
- rdata:
  - Holds its last captured value between reads; only rvalid qualifies it.
  - rdata is not cleared on a write.
- RAM strobes:
  - ram_write_enable and ram_read are registered and driven by state, so they are glitch-free.
  - They are never both high.
  - They are never high outside ACCESS.
- Reset in ACCESS:
  - ram_write_enable is gated by !reset, so no RAM write occurs at that edge.
  - The FSM returns to IDLE with no ack, rvalid or err.
- Reset in RESP: the ack is suppressed.
- Simultaneous requests: grants alternate 0,1,0,1 while both are held. No starvation; the worst-case wait is 3 cycles per other requester.
- Address width rule: only the full ADDR_W compare against DEPTH decides the range check. Addresses 8..65535 are never forwarded to the RAM.

Decomposition:
- Package ram_arb_pkg:
  - typedef arb_state_t {IDLE, ACCESS, RESP}.
  - localparam defaults for ADDR_W, DATA_W and DEPTH.
- One sub-module, rr_pick:
  - Purely combinational N_REQ round-robin priority picker.
  - Inputs: req vector and last_grant. Outputs: one-hot grant and winner index.

Test Plan:
1. Write then read, single requester: after reset, port0 writes addr=3, wdata=16'hBEEF, then reads addr=3. Required: write ack at cycle 2, ram_write_enable high exactly one cycle with ram_address=3. Read returns ack[0] and rvalid[0] together with rdata=16'hBEEF.
2. Contention fairness: both ports request reads of addr 0 and 1 continuously for 12 cycles. Required: acks alternate port0, port1, port0, port1, 3 cycles apart. Each rdata matches the preloaded RAM contents.
3. Out of range: port1 writes addr=16'h0008, wdata=16'h1234. Required: ack[1] and err[1] in RESP, ram_write_enable never asserted. A subsequent read of addr 0 returns its unchanged value.
4. Reset mid-write: reset asserted during the ACCESS cycle of a port0 write to addr 5 of 16'hAAAA. Required: no ack, and the FSM is in IDLE after the edge. A read of addr 5 returns the old value, not 16'hAAAA.
5. Back-to-back same requester: port0 holds req high across ack with a new addr 2, then addr 7. Required: a second grant with no idle gap beyond IDLE, and rvalid plus correct data for each read.
6. Idle quiescence: no requests for 20 cycles. Required: all outputs remain 0 except rdata, which holds its last value, and the state stays IDLE.
